// File: rtl/sl_vpos_gen_if.sv
// Video timing in / scanline position out bundle for sl_vpos_gen.
interface sl_vpos_gen_if #(
  parameter int unsigned LINECNT_WIDTH = 11
);

  logic                     HSYNC_i;
  logic                     VSYNC_i;
  logic                     DE_i;
  logic                     sl_en_i;
  logic [16:0]              v_step_i;
  logic [7:0]               v_offset_i;
  logic [7:0]               sl_rel_pos_o;
  logic [LINECNT_WIDTH-1:0] src_line_o;
  logic                     sl_en_o;
  logic                     line_start_o;

  // Position generator side.
  modport slave (
    input  HSYNC_i, VSYNC_i, DE_i, sl_en_i, v_step_i, v_offset_i,
    output sl_rel_pos_o, src_line_o, sl_en_o, line_start_o
  );

  // Timing source / consumer side.
  modport master (
    output HSYNC_i, VSYNC_i, DE_i, sl_en_i, v_step_i, v_offset_i,
    input  sl_rel_pos_o, src_line_o, sl_en_o, line_start_o
  );

endinterface

// File: rtl/sl_vpos_gen.sv
// Per-output-line vertical sub-position generator for scanline emulation.
// A Q0.16 phase advances by a Q1.16 step at the end of every active output
// line; its carry walks the source line index. All outputs change only at
// line boundaries (or the frame-start reload) and stay stable in between.
module sl_vpos_gen #(
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LINECNT_WIDTH   = 11
) (
  input logic          VCLK_i,
  input logic          VRST_i,
  sl_vpos_gen_if.slave vp
);

  localparam int unsigned STEP_W  = 17;
  localparam int unsigned PHASE_W = 16;
  localparam int unsigned POS_W   = 8;

  localparam logic [STEP_W-1:0]        STEP_UNITY = STEP_W'(17'h10000);
  localparam logic [LINECNT_WIDTH-1:0] LINE_MAX   = '1;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    WAIT_DE = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t                   state_q, state_nxt;
  logic                     hs_q, hs_qq, vs_q, vs_qq;
  logic                     hs_act_c, vs_act_c, hs_lead_c, vs_lead_c;
  logic [PHASE_W-1:0]       phase_q, phase_nxt;
  logic [STEP_W-1:0]        step_q, step_nxt, step_cfg_c;
  logic                     de_seen_q, de_seen_nxt;
  logic [POS_W-1:0]         rel_pos_q, rel_pos_nxt;
  logic [LINECNT_WIDTH-1:0] src_line_q, src_line_nxt;
  logic                     sl_en_q, sl_en_nxt;
  logic                     line_start_q, line_start_nxt;
  logic [PHASE_W:0]         phase_sum_c;
  logic                     line_carry_c;

  // Normalise sync polarity so that 1 always means "sync active".
  assign hs_act_c  = SYNC_ACTIVE_LOW ? ~vp.HSYNC_i : vp.HSYNC_i;
  assign vs_act_c  = SYNC_ACTIVE_LOW ? ~vp.VSYNC_i : vp.VSYNC_i;
  assign hs_lead_c = hs_q & ~hs_qq;
  assign vs_lead_c = vs_q & ~vs_qq;

  // Zero and out-of-range steps both collapse to one source line per line.
  assign step_cfg_c = ((vp.v_step_i == '0) || (vp.v_step_i > STEP_UNITY)) ?
                      STEP_UNITY : vp.v_step_i;

  // Fractional part wraps mod 2^16; integer part of the step always carries.
  assign phase_sum_c  = {1'b0, phase_q} + {1'b0, step_q[PHASE_W-1:0]};
  assign line_carry_c = phase_sum_c[PHASE_W] | step_q[PHASE_W];

  assign vp.sl_rel_pos_o = rel_pos_q;
  assign vp.src_line_o   = src_line_q;
  assign vp.sl_en_o      = sl_en_q;
  assign vp.line_start_o = line_start_q;

  // Sync input register and history; history resets inactive to avoid false edges.
  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      hs_q  <= 1'b0;
      hs_qq <= 1'b0;
      vs_q  <= 1'b0;
      vs_qq <= 1'b0;
    end else begin
      hs_q  <= hs_act_c;
      hs_qq <= hs_q;
      vs_q  <= vs_act_c;
      vs_qq <= vs_q;
    end
  end

  // Next-state, phase update and line-boundary output refresh.
  always_comb begin
    state_nxt      = state_q;
    phase_nxt      = phase_q;
    step_nxt       = step_q;
    de_seen_nxt    = de_seen_q;
    rel_pos_nxt    = rel_pos_q;
    src_line_nxt   = src_line_q;
    sl_en_nxt      = sl_en_q;
    line_start_nxt = 1'b0;

    if (vs_lead_c) begin
      // Frame start wins over any coincident line boundary.
      state_nxt      = WAIT_DE;
      phase_nxt      = {vp.v_offset_i, 8'h00};
      step_nxt       = step_cfg_c;
      de_seen_nxt    = 1'b0;
      rel_pos_nxt    = vp.v_offset_i;
      src_line_nxt   = '0;
      sl_en_nxt      = 1'b0;
      line_start_nxt = 1'b1;
    end else begin
      case (state_q)
        WAIT_VS: begin
        end
        WAIT_DE: begin
          if (vp.DE_i) begin
            state_nxt   = ACTIVE;
            de_seen_nxt = 1'b1;
          end
        end
        ACTIVE: begin
          if (hs_lead_c) begin
            de_seen_nxt    = 1'b0;
            sl_en_nxt      = vp.sl_en_i;
            line_start_nxt = 1'b1;
            if (de_seen_q) begin
              phase_nxt   = phase_sum_c[PHASE_W-1:0];
              rel_pos_nxt = phase_sum_c[PHASE_W-1 -: POS_W];
              if (line_carry_c && (src_line_q != LINE_MAX)) begin
                src_line_nxt = src_line_q + LINECNT_WIDTH'(1);
              end
            end else begin
              rel_pos_nxt = phase_q[PHASE_W-1 -: POS_W];
            end
          end else if (vp.DE_i) begin
            de_seen_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = WAIT_VS;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge VCLK_i) begin
    if (VRST_i) begin
      state_q      <= WAIT_VS;
      phase_q      <= '0;
      step_q       <= STEP_UNITY;
      de_seen_q    <= 1'b0;
      rel_pos_q    <= '0;
      src_line_q   <= '0;
      sl_en_q      <= 1'b0;
      line_start_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      phase_q      <= phase_nxt;
      step_q       <= step_nxt;
      de_seen_q    <= de_seen_nxt;
      rel_pos_q    <= rel_pos_nxt;
      src_line_q   <= src_line_nxt;
      sl_en_q      <= sl_en_nxt;
      line_start_q <= line_start_nxt;
    end
  end

endmodule

// File: doc/sl_vpos_gen.md
Name: sl_vpos_gen

Overview:
- Generates the per-output-line vertical sub-position (sl_rel_pos) consumed by the scanline emulation stage directly downstream.
- Tracks a fractional phase accumulator that advances by a programmable source-lines-per-output-line step on every completed active output line, reloading at each frame start.
- Also provides the source-line index and a gated scanline enable, all held stable for a whole output line.

Parameters:
- SYNC_ACTIVE_LOW, 1: 1 = HSYNC_i/VSYNC_i are active-low, 0 = active-high.
- LINECNT_WIDTH, 11: width of src_line_o.

Ports:
- VCLK_i  in  1  video clock; single clock domain.
- VRST_i  in  1  synchronous reset, active-high.
- HSYNC_i  in  1  horizontal sync, polarity per SYNC_ACTIVE_LOW.
- VSYNC_i  in  1  vertical sync, polarity per SYNC_ACTIVE_LOW.
- DE_i  in  1  data enable, active-high.
- sl_en_i  in  1  scanline feature enable from config.
- v_step_i  in  17  Q1.16 source lines per output line. Valid range is 0x00001..0x10000.
- v_offset_i  in  8  initial phase at frame start, Q0.8.
- sl_rel_pos_o  out  8  phase[15:8]; feeds the scanline stage's rel-pos input.
- src_line_o  out  LINECNT_WIDTH  source line index within the frame.
- sl_en_o  out  1  sl_en_i gated with "inside active frame region".
- line_start_o  out  1  one-cycle pulse when the outputs above update.

Behaviour:
- Clock and reset: one clock, VCLK_i. VRST_i is synchronous, active-high, and sampled on the VCLK_i rising edge.
- Reset values:
  - Outputs: sl_rel_pos_o=0x00, src_line_o=0, sl_en_o=0, line_start_o=0.
  - Internal: state=WAIT_VS, phase=0, step_r=0x10000, de_seen=0.
  - Sync-edge history registers reset to the inactive level, so no false edge follows reset.
- Edge detection:
  - hs_lead and vs_lead are the first cycle the registered sync becomes active (1-cycle input register plus compare).
  - Detection latency is 1 cycle after the pin changes.
- Config sampling: v_step_i and v_offset_i are captured into step_r and offs_r only on vs_lead.
  - step 0 is treated as 0x10000.
  - step > 0x10000 is clamped to 0x10000.
- State machine:
  - WAIT_VS: outputs hold. On vs_lead: phase={v_offset_i,8'h00}, src_line=0, load config, go to WAIT_DE.
  - WAIT_DE: waits for the first DE_i=1 in the frame, then goes to ACTIVE. sl_en_o=0. Outputs show the initial phase.
  - ACTIVE:
    - de_seen is set by any DE_i=1 during the current line.
    - On hs_lead with de_seen=1: {carry,phase} = phase + step_r (17-bit add, 16-bit phase), and src_line += carry + step_r[16].
    - src_line saturates at all-ones and never wraps.
    - de_seen clears on every hs_lead.
    - On hs_lead with de_seen=0 (blank line): phase is unchanged.
    - sl_en_o = sl_en_i, registered.
  - vs_lead in any state (including ACTIVE mid-line): reload exactly as from WAIT_VS and go to WAIT_DE.
  - vs_lead and hs_lead in the same cycle: VSYNC wins and no phase advance occurs.
- Output timing:
  - On the cycle after hs_lead, or after the vs reload, sl_rel_pos_o, src_line_o and sl_en_o update together and line_start_o pulses for exactly 1 cycle.
  - Outputs are otherwise constant.
  - Total latency is 2 VCLK_i cycles from the HSYNC pin edge to the new outputs, well before DE of that line.
- Arithmetic:
  - Phase wrap-around is modulo 2^16, with the carry going to src_line.
  - step_r = 0x10000 gives a constant phase, with src_line incrementing every active line.
  - sl_rel_pos_o is truncated with no rounding.
- Reset mid-frame: reset takes priority over everything and returns to the reset values. The first valid outputs follow the next vs_lead.

Test Plan:
- Reset/idle: assert VRST_i for 3 cycles during active video → all outputs 0 next cycle. Stays in WAIT_VS, with no line_start_o pulse before the first VSYNC.
- 2x upscale: v_step=0x08000, v_offset=0x00, 6 active lines → sl_rel_pos_o sequence 0x00,0x80,0x00,0x80,0x00,0x80; src_line_o 0,0,1,1,2,2; each update exactly 2 cycles after the HSYNC edge.
- Offset and non-integer step: v_step=0x05556, v_offset=0x40 → sl_rel_pos_o 0x40,0x95,0xEA,0x40 (wrap, src_line 1); line_start_o width exactly 1 cycle.
- Blank lines and step edge cases:
  - 3 HSYNCs with DE low between active lines → phase unchanged.
  - v_step=0 → behaves as 0x10000: sl_rel_pos_o constant 0x40, src_line increments each line.
  - v_step=0x1FFFF → clamped to the same behaviour.
- Mid-frame VSYNC and config change: change v_step mid-frame → no effect until the next VSYNC. Coincident HSYNC+VSYNC edge → reload to offset, no advance, sl_en_o=0 until first DE.
- Saturation and sl_en: 2100 active lines with step 0x10000 and LINECNT_WIDTH=11 → src_line_o holds 0x7FF. Toggling sl_en_i mid-line → sl_en_o changes only at the next line_start_o.
